// File: rtl/dds_core_param.sv
// Parametrised single-channel DDS core: sine/triangle/sawtooth/square, offset-binary output, 3-stage pipeline.
// Optional linear frequency sweep is built when DDS_SWEEP_EN is defined.
module dds_core_param #(
  parameter int ACC_W  = 32,
  parameter int PH_W   = 12,
  parameter int LUT_AW = 8,
  parameter int DATA_W = 10,
  parameter int AMP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_addr,
  input  logic [ACC_W-1:0]  cfg_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int PW = DATA_W + AMP_W + 1;
  localparam logic [1:0] WAVE_SINE = 2'd0, WAVE_TRI = 2'd1, WAVE_SAW = 2'd2, WAVE_SQUARE = 2'd3;

  // Bhaskara sine approximation, evaluated at elaboration only: entry i = peak*sin(pi/2 * i/2^LUT_AW).
  function automatic logic [DATA_W-2:0] sine_entry(input int idx);
    longint m, a, den, peak;
    m    = longint'(1) << (LUT_AW + 1);
    a    = longint'(idx) * (m - longint'(idx));
    den  = 5 * m * m - 4 * a;
    peak = (longint'(1) << (DATA_W - 1)) - 1;
    return (DATA_W-1)'((32 * peak * a + den) / (2 * den));
  endfunction

  logic [DATA_W-2:0] sine_lut [2**LUT_AW];
  for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_lut
    assign sine_lut[gi] = sine_entry(gi);
  end

  // Handshake: a write is taken on a clk edge with cfg_valid && cfg_ready; cfg_ready is the inverse of
  // the pending-commit flag, so it drops after a commit and returns once the commit lands on a sample_en.
  logic              pending, cfg_accept, apply;
  logic [ACC_W-1:0]  freq_shadow, freq_active, freq_eff, acc;
  logic [PH_W-1:0]   phase_shadow, phase_active, phase_eff;
  logic [AMP_W-1:0]  amp_shadow, amp_active, amp_eff;
  logic [1:0]        wave_shadow, wave_active, wave_eff;

  assign cfg_ready  = ~pending;
  assign cfg_accept = cfg_valid & cfg_ready;
  assign apply      = sample_en & pending;
  // A pending commit is used by the very sample that applies it.
  assign freq_eff   = pending ? freq_shadow  : freq_active;
  assign phase_eff  = pending ? phase_shadow : phase_active;
  assign amp_eff    = pending ? amp_shadow   : amp_active;
  assign wave_eff   = pending ? wave_shadow  : wave_active;

`ifdef DDS_SWEEP_EN
  logic [ACC_W-1:0] step_shadow, limit_shadow, step_active, limit_active, freq_base;
  logic [ACC_W:0]   sweep_sum;
  assign sweep_sum = {1'b0, freq_active} + {1'b0, step_active};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= 1'b0;
      freq_shadow  <= '0;
      phase_shadow <= '0;
      amp_shadow   <= '1;
      wave_shadow  <= WAVE_SINE;
`ifdef DDS_SWEEP_EN
      step_shadow  <= '0;
      limit_shadow <= '0;
`endif
    end else begin
      if (apply) pending <= 1'b0;
      if (cfg_accept) begin
        case (cfg_addr)
          3'd0: freq_shadow  <= cfg_data;
          3'd1: phase_shadow <= cfg_data[PH_W-1:0];
          3'd2: amp_shadow   <= cfg_data[AMP_W-1:0];
          3'd3: wave_shadow  <= cfg_data[1:0];
          3'd4: pending      <= 1'b1;
`ifdef DDS_SWEEP_EN
          3'd5: step_shadow  <= cfg_data;
          3'd6: limit_shadow <= cfg_data;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_active  <= '0;
      phase_active <= '0;
      amp_active   <= '1;
      wave_active  <= WAVE_SINE;
`ifdef DDS_SWEEP_EN
      step_active  <= '0;
      limit_active <= '0;
      freq_base    <= '0;
`endif
    end else if (apply) begin
      freq_active  <= freq_shadow;
      phase_active <= phase_shadow;
      amp_active   <= amp_shadow;
      wave_active  <= wave_shadow;
`ifdef DDS_SWEEP_EN
      step_active  <= step_shadow;
      limit_active <= limit_shadow;
      freq_base    <= freq_shadow;
    end else if (sample_en && (step_active != '0)) begin
      if (sweep_sum >= {1'b0, limit_active}) freq_active <= freq_base;
      else                                   freq_active <= sweep_sum[ACC_W-1:0];
`endif
    end
  end

  // S0: phase accumulate; the phase word uses the pre-increment accumulator.
  logic [PH_W-1:0]  s0_p;
  logic [1:0]       s0_wave;
  logic [AMP_W-1:0] s0_amp;
  logic             s0_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      s0_p     <= '0;
      s0_wave  <= WAVE_SINE;
      s0_amp   <= '0;
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= sample_en;
      if (sample_en) begin
        acc     <= acc + freq_eff;
        s0_p    <= acc[ACC_W-1 -: PH_W] + phase_eff;
        s0_wave <= wave_eff;
        s0_amp  <= amp_eff;
      end
    end
  end

  // S1: waveform shaping into a signed DATA_W value.
  logic [1:0]        quad;
  logic [LUT_AW-1:0] lut_idx, lut_addr;
  logic [DATA_W-1:0] sine_mag, sine_w, tri_u, saw_u, wave_w;
  logic [PH_W-2:0]   fold;

  assign quad     = s0_p[PH_W-1 -: 2];
  assign lut_idx  = LUT_AW'({s0_p[PH_W-3:0], {LUT_AW{1'b0}}} >> (PH_W - 2));
  assign lut_addr = quad[0] ? ~lut_idx : lut_idx;
  assign sine_mag = {1'b0, sine_lut[lut_addr]};
  assign sine_w   = quad[1] ? (DATA_W'(0) - sine_mag) : sine_mag;
  assign fold     = s0_p[PH_W-1] ? ~s0_p[PH_W-2:0] : s0_p[PH_W-2:0];
  assign tri_u    = DATA_W'({fold, {DATA_W{1'b0}}} >> (PH_W - 1));
  assign saw_u    = DATA_W'({s0_p, {DATA_W{1'b0}}} >> PH_W);

  always_comb begin
    wave_w = sine_w;
    case (s0_wave)
      WAVE_TRI:    wave_w = {~tri_u[DATA_W-1], tri_u[DATA_W-2:0]};
      WAVE_SAW:    wave_w = {~saw_u[DATA_W-1], saw_u[DATA_W-2:0]};
      WAVE_SQUARE: wave_w = s0_p[PH_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      default:     wave_w = sine_w;
    endcase
  end

  logic [DATA_W-1:0] s1_w;
  logic [AMP_W-1:0]  s1_amp;
  logic              s1_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_w     <= '0;
      s1_amp   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_w   <= wave_w;
        s1_amp <= s0_amp;
      end
    end
  end

  // S2: amplitude scale (floor via arithmetic shift) and offset-binary conversion by MSB flip.
  logic signed [PW-1:0] w_ext, amp_ext;
  logic [DATA_W-1:0]    scaled;

  assign w_ext   = PW'($signed(s1_w));
  assign amp_ext = PW'({1'b0, s1_amp});
  assign scaled  = DATA_W'((w_ext * amp_ext) >>> AMP_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= {1'b1, {(DATA_W-1){1'b0}}};
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= s1_valid;
      if (s1_valid) dout <= {~scaled[DATA_W-1], scaled[DATA_W-2:0]};
    end
  end

endmodule

// File: tb/tb_dds_core_param.sv
// Directed bench for dds_core_param: hand-computed sample table per scenario, scoreboard queue, latency monitor.
module tb_dds_core_param;

  localparam int DATA_W = 10;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_en = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_addr = '0;
  logic [ACC_W-1:0]  cfg_data = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  dds_core_param dut (
    .clk        (clk),
    .reset      (rst_n),
    .sample_en  (sample_en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change on negedge; every task starts and ends just after a negedge
  task automatic tick(input int gap);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [ACC_W-1:0] data);
    int waited;
    waited    = 0;
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    while (!cfg_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited == 50) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_write(3'd4, '0);
  endtask

  // scoreboard / monitor: dout_valid must follow a sampled sample_en by exactly 3 clk
  logic h0 = 1'b0, h1 = 1'b0, se_edge;
  always begin
    @(posedge clk);
    se_edge = sample_en;
    #1;
    if (!rst_n) begin
      h0 = 1'b0;
      h1 = 1'b0;
    end else begin
      if (h1 || dout_valid) check("dout_valid", 32'(dout_valid), 32'(h1));
      if (dout_valid) begin
        if (exp_q.size() == 0) check("unexpected_sample", 32'd1, 32'd0);
        else                   check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
      h1 = h0;
      h0 = se_edge;
    end
  end

  logic [DATA_W-1:0] seq_sine128 [4] = '{10'd512, 10'd256, 10'd512, 10'd767};
  logic [ACC_W-1:0]  sweep_exp   [4] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h1000_0000};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'd512);
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // idle defaults: freq 0 -> mid-scale
    repeat (4) begin
      exp_q.push_back(10'd512);
      tick(3);
    end

    // sine at freq 2^30, full amplitude
    cfg_write(3'd0, 32'h4000_0000);
    commit();
    check("ready_low_after_commit", 32'(cfg_ready), 32'd0);
    foreach (seq_sine128[i]) ;
    exp_q.push_back(10'd512); exp_q.push_back(10'd1021); exp_q.push_back(10'd512);
    exp_q.push_back(10'd2);   exp_q.push_back(10'd512);
    tick(3);
    check("ready_high_after_apply", 32'(cfg_ready), 32'd1);
    repeat (4) tick(3);

    // square
    cfg_write(3'd3, 32'd3);
    commit();
    exp_q.push_back(10'd1021); exp_q.push_back(10'd2); exp_q.push_back(10'd2);
    exp_q.push_back(10'd1021); exp_q.push_back(10'd1021);
    repeat (5) tick(3);

    // commit on the same clk as sample_en: that sample keeps old settings
    cfg_write(3'd3, 32'd0);
    cfg_write(3'd2, 32'd128);
    exp_q.push_back(10'd2);
    cfg_valid = 1'b1;
    cfg_addr  = 3'd4;
    sample_en = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    sample_en = 1'b0;
    check("ready_low_commit_on_tick", 32'(cfg_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("ready_still_low", 32'(cfg_ready), 32'd0);
    exp_q.push_back(10'd256); exp_q.push_back(10'd512); exp_q.push_back(10'd767);
    tick(3);
    check("ready_high_after_late_apply", 32'(cfg_ready), 32'd1);
    repeat (2) tick(3);

    // shadow-only writes (plus addr 5/6/7) must not disturb 100 back-to-back samples
    cfg_write(3'd0, 32'd12345);
    cfg_write(3'd5, 32'h1000_0000);
    cfg_write(3'd6, 32'h2000_0000);
    cfg_write(3'd7, 32'h0000_dead);
    check("ready_after_addr7", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(seq_sine128[i % 4]);
      tick(0);
    end
    repeat (4) @(negedge clk);

    // sawtooth with phase offset 512
    cfg_write(3'd0, 32'h4000_0000);
    cfg_write(3'd1, 32'd512);
    cfg_write(3'd2, 32'd255);
    cfg_write(3'd3, 32'd2);
`ifdef DDS_SWEEP_EN
    cfg_write(3'd5, 32'd0);
`endif
    commit();
    exp_q.push_back(10'd639); exp_q.push_back(10'd894); exp_q.push_back(10'd129); exp_q.push_back(10'd384);
    repeat (4) tick(3);

    // triangle, no phase offset
    cfg_write(3'd1, 32'd0);
    cfg_write(3'd3, 32'd1);
    commit();
    exp_q.push_back(10'd1021); exp_q.push_back(10'd511); exp_q.push_back(10'd2); exp_q.push_back(10'd512);
    repeat (4) tick(3);

    // sawtooth with phase 3584: phase sum wraps mod 2^PH_W
    cfg_write(3'd1, 32'd3584);
    cfg_write(3'd3, 32'd2);
    commit();
    exp_q.push_back(10'd384); exp_q.push_back(10'd639);
    repeat (2) tick(3);
    repeat (6) @(negedge clk);

    // reset with a sample in flight: it must vanish
    tick(1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_dout_valid", 32'(dout_valid), 32'd0);
    check("midreset_dout", 32'(dout), 32'd512);
    check("midreset_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(10'd512); exp_q.push_back(10'd512);
    repeat (2) tick(3);

`ifdef DDS_SWEEP_EN
    // linear sweep: 2^28 step, 2^30 limit, amplitude 0 keeps dout at mid-scale
    cfg_write(3'd2, 32'd0);
    cfg_write(3'd0, 32'h1000_0000);
    cfg_write(3'd5, 32'h1000_0000);
    cfg_write(3'd6, 32'h4000_0000);
    commit();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(10'd512);
      tick(3);
      check("sweep_freq", dut.freq_active, sweep_exp[i]);
    end
`endif

    repeat (10) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
